// File: rtl/tcp_tx_arbiter.sv
// Round-robin arbiter merging N_REQ byte streams onto one TCP TX byte stream.
// Latency: 1 cycle IDLE->BUSY arbitration; accepted beat appears on TX_WR/TX_DATA 1 cycle later.
// Backpressure: REQ_READY drops combinationally on TX_FULL, link down or abort; grant held without timeout.
`timescale 1ns/1ps

module tcp_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 256
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               TCP_OPEN,
  input  logic               TCP_RST,
  input  logic               TX_FULL,
  output logic               TX_WR,
  output logic [7:0]         TX_DATA,
  input  logic [N_REQ-1:0]   REQ_VALID,
  input  logic [8*N_REQ-1:0] REQ_DATA,
  input  logic [N_REQ-1:0]   REQ_LAST,
  output logic [N_REQ-1:0]   REQ_READY,
  output logic [N_REQ-1:0]   GRANT,
  output logic [31:0]        TX_BYTES
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [1:0]       rst_sync;
  logic             rst_n_int;
  state_t           state, state_nx;
  logic [N_REQ-1:0] grant_nx;
  logic [IW-1:0]    grant_idx, grant_idx_nx;
  logic [IW-1:0]    last_served, last_nx;
  logic [BW-1:0]    burst_cnt, burst_nx;
  logic             link_ok;
  logic             accept;
  logic [7:0]       beat_data;
  logic             beat_last;
  logic             rr_found;
  logic [IW-1:0]    rr_pick;
  logic [IW-1:0]    cand_idx;
  int               cand;
  logic             open_d;
  logic [31:0]      tx_bytes_q;

  // Reset asserts immediately but releases only after two clean CLK edges.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign link_ok   = TCP_OPEN & ~TCP_RST;
  assign REQ_READY = GRANT & {N_REQ{link_ok & ~TX_FULL}};
  assign accept    = |(REQ_VALID & REQ_READY);
  assign TX_BYTES  = tx_bytes_q;

  // Select the granted requester's byte and last flag (GRANT is one-hot or zero).
  always_comb begin
    beat_data = 8'h00;
    beat_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (GRANT[i]) begin
        beat_data = REQ_DATA[i*8 +: 8];
        beat_last = REQ_LAST[i];
      end
    end
  end

  // Round-robin search starting one past the last-served requester.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_served) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IW'(cand);
      if (!rr_found && REQ_VALID[cand_idx]) begin
        rr_found = 1'b1;
        rr_pick  = cand_idx;
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state       <= IDLE;
      GRANT       <= '0;
      grant_idx   <= '0;
      last_served <= IW'(N_REQ - 1);
      burst_cnt   <= '0;
    end else begin
      state       <= state_nx;
      GRANT       <= grant_nx;
      grant_idx   <= grant_idx_nx;
      last_served <= last_nx;
      burst_cnt   <= burst_nx;
    end
  end

  // Next-state: grant on any request, release on last beat, burst limit or link loss.
  always_comb begin
    state_nx     = state;
    grant_nx     = GRANT;
    grant_idx_nx = grant_idx;
    last_nx      = last_served;
    burst_nx     = burst_cnt;
    if (state == IDLE) begin
      grant_nx = '0;
      if (link_ok && rr_found) begin
        state_nx     = BUSY;
        grant_idx_nx = rr_pick;
        grant_nx     = N_REQ'(1) << rr_pick;
        burst_nx     = '0;
      end
    end else begin
      if (!link_ok) begin
        // Abort: the interrupted requester loses its turn and re-competes later.
        state_nx = IDLE;
        grant_nx = '0;
        last_nx  = grant_idx;
      end else if (accept) begin
        burst_nx = burst_cnt + 1'b1;
        if (beat_last || burst_cnt == BW'(MAX_BURST - 1)) begin
          state_nx = IDLE;
          grant_nx = '0;
          last_nx  = grant_idx;
        end
      end
    end
  end

  // Registered TX write path; data holds when no write.
  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      TX_WR   <= 1'b0;
      TX_DATA <= 8'h00;
    end else begin
      TX_WR <= accept;
      if (accept) TX_DATA <= beat_data;
    end
  end

  // Byte counter: cleared on connection open (clear beats a coincident write), wraps naturally.
  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      open_d     <= 1'b0;
      tx_bytes_q <= 32'd0;
    end else begin
      open_d <= TCP_OPEN;
      if (TCP_OPEN && !open_d) tx_bytes_q <= 32'd0;
      else if (TX_WR)          tx_bytes_q <= tx_bytes_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
`timescale 1ns/1ps

module tb_tcp_tx_arbiter;
  localparam int NR = 4;
  localparam int MB = 4;

  logic            CLK = 1'b0;
  logic            RSTn = 1'b0;
  logic            TCP_OPEN = 1'b0;
  logic            TCP_RST = 1'b0;
  logic            TX_FULL = 1'b0;
  logic            TX_WR;
  logic [7:0]      TX_DATA;
  logic [NR-1:0]   REQ_VALID = '0;
  logic [8*NR-1:0] REQ_DATA = '0;
  logic [NR-1:0]   REQ_LAST = '0;
  logic [NR-1:0]   REQ_READY;
  logic [NR-1:0]   GRANT;
  logic [31:0]     TX_BYTES;

  tcp_tx_arbiter #(.N_REQ(NR), .MAX_BURST(MB)) dut (
    .CLK(CLK), .RSTn(RSTn), .TCP_OPEN(TCP_OPEN), .TCP_RST(TCP_RST), .TX_FULL(TX_FULL),
    .TX_WR(TX_WR), .TX_DATA(TX_DATA), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
    .REQ_LAST(REQ_LAST), .REQ_READY(REQ_READY), .GRANT(GRANT), .TX_BYTES(TX_BYTES)
  );

  always #5 CLK = ~CLK;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  rq_dat [NR][64];
  bit          rq_lst [NR][64];
  int          rq_hd  [NR];
  int          rq_tl  [NR];
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_b;
  int          acc_cyc [$];
  int          cyc = 0;
  int          wr_total = 0;
  int          acc_total = 0;
  logic        acc_flag = 1'b0;
  bit          chk_en = 1'b1;
  int          wr0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic load(input int r, input logic [7:0] base, input int n);
    for (int j = 0; j < n; j++) begin
      rq_dat[r][rq_tl[r] + j] = base + 8'(j);
      rq_lst[r][rq_tl[r] + j] = (j == n - 1);
    end
    rq_tl[r] = rq_tl[r] + n;
  endtask

  task automatic push_exp(input logic [7:0] base, input int n);
    for (int j = 0; j < n; j++) exp_q.push_back(base + 8'(j));
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < NR; i++) if (rq_hd[i] != rq_tl[i]) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string name);
    int k = 0;
    while (k < 300 && !(all_empty() && exp_q.size() == 0)) begin
      @(negedge CLK); #2; k++;
    end
    check(name, k < 300, 1'b1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic wait_acc(input int n, input string name);
    int target = acc_total + n;
    int k = 0;
    do begin @(negedge CLK); k++; end while (acc_total < target && k < 200);
    check(name, acc_total >= target, 1'b1);
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Requester models: present queue heads at negedge, record acceptances just after.
  always @(negedge CLK) begin
    for (int i = 0; i < NR; i++) begin
      REQ_VALID[i]       = rq_hd[i] < rq_tl[i];
      REQ_DATA[i*8 +: 8] = REQ_VALID[i] ? rq_dat[i][rq_hd[i]] : 8'h00;
      REQ_LAST[i]        = REQ_VALID[i] & rq_lst[i][rq_hd[i]];
    end
    #1;
    acc_flag = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (REQ_VALID[i] && REQ_READY[i]) begin
        rq_hd[i]++;
        acc_flag = 1'b1;
        acc_total++;
        acc_cyc.push_back(cyc);
      end
    end
  end

  // Output monitor / scoreboard.
  always @(negedge CLK) begin
    if (TX_WR) wr_total++;
    if (chk_en) begin
      if (TX_WR || acc_flag) check("wr_one_cycle_after_accept", TX_WR, acc_flag);
      if (TX_WR) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_extra: got write %h, required none", TX_DATA);
        end else begin
          exp_b = exp_q.pop_front();
          check("tx_data", TX_DATA, exp_b);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin rq_hd[i] = 0; rq_tl[i] = 0; end

    // Reset state
    repeat (3) @(negedge CLK);
    #2;
    check("rst_grant", GRANT, 4'b0000);
    check("rst_tx_wr", TX_WR, 1'b0);
    check("rst_tx_data", TX_DATA, 8'h00);
    check("rst_tx_bytes", TX_BYTES, 32'd0);
    check("rst_ready", REQ_READY, 4'b0000);
    @(negedge CLK);
    RSTn = 1'b1;
    TCP_OPEN = 1'b1;
    repeat (4) @(negedge CLK);

    // Two 3-byte packets from requesters 0 and 2
    @(posedge CLK); #2;
    acc_cyc.delete();
    load(0, 8'h10, 3);
    load(2, 8'h20, 3);
    push_exp(8'h10, 3);
    push_exp(8'h20, 3);
    @(negedge CLK);
    @(negedge CLK); #2;
    check("a_first_grant", GRANT, 4'b0001);
    drain("a_drain");
    check("a_accepts", acc_cyc.size(), 6);
    check("a_b2b_0", acc_cyc[1] - acc_cyc[0], 1);
    check("a_b2b_1", acc_cyc[2] - acc_cyc[1], 1);
    check("a_gap_between_pkts", acc_cyc[3] - acc_cyc[2], 2);
    check("a_tx_data_hold", TX_DATA, 8'h22);
    check("a_tx_bytes", TX_BYTES, 32'd6);

    // Burst limit: req1 10 bytes, req3 2 bytes, after a connection reopen
    @(negedge CLK); TCP_OPEN = 1'b0;
    @(negedge CLK); TCP_OPEN = 1'b1;
    @(negedge CLK);
    @(posedge CLK); #2;
    load(1, 8'h30, 10);
    @(negedge CLK);
    @(posedge CLK); #2;
    load(3, 8'h50, 2);
    push_exp(8'h30, 4);
    push_exp(8'h50, 2);
    push_exp(8'h34, 6);
    drain("b_drain");
    check("b_tx_bytes", TX_BYTES, 32'd12);

    // TX_FULL for 5 cycles mid-packet
    @(posedge CLK); #2;
    load(2, 8'h70, 4);
    push_exp(8'h70, 4);
    wait_acc(2, "c_wait");
    TX_FULL = 1'b1;
    #2;
    wr0 = wr_total;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) begin @(negedge CLK); #2; end
      check("c_ready_stalled", REQ_READY, 4'b0000);
      check("c_grant_held", GRANT, 4'b0100);
    end
    @(negedge CLK);
    TX_FULL = 1'b0;
    #2;
    check("c_writes_after_full", (wr_total - wr0) <= 1, 1'b1);
    drain("c_drain");
    check("c_tx_bytes", TX_BYTES, 32'd16);

    // TCP_OPEN dropped after byte 2 of a 6-byte packet
    @(posedge CLK); #2;
    load(3, 8'h80, 6);
    push_exp(8'h80, 6);
    wait_acc(2, "d_wait");
    TCP_OPEN = 1'b0;
    #2;
    check("d_ready_closed", REQ_READY, 4'b0000);
    wr0 = wr_total;
    @(negedge CLK); #2;
    check("d_grant_dropped", GRANT, 4'b0000);
    repeat (3) @(negedge CLK);
    #2;
    check("d_no_writes_closed", wr_total - wr0, 0);
    @(negedge CLK);
    TCP_OPEN = 1'b1;
    @(negedge CLK); #2;
    check("d_bytes_clear_on_open", TX_BYTES, 32'd0);
    drain("d_drain");
    check("d_tx_bytes", TX_BYTES, 32'd4);

    // TCP_RST abort keeps TX_BYTES
    @(posedge CLK); #2;
    load(1, 8'h90, 3);
    push_exp(8'h90, 3);
    wait_acc(1, "e_wait");
    TCP_RST = 1'b1;
    #2;
    check("e_ready_abort", REQ_READY, 4'b0000);
    @(negedge CLK);
    TCP_RST = 1'b0;
    #2;
    check("e_grant_abort", GRANT, 4'b0000);
    check("e_bytes_kept", TX_BYTES, 32'd5);
    drain("e_drain");
    check("e_tx_bytes", TX_BYTES, 32'd7);

    // RSTn pulse mid-burst
    chk_en = 1'b0;
    @(posedge CLK); #2;
    load(1, 8'hC0, 4);
    wait_acc(1, "f_wait");
    #2;
    RSTn = 1'b0;
    #1;
    check("f_rst_grant", GRANT, 4'b0000);
    check("f_rst_tx_wr", TX_WR, 1'b0);
    check("f_rst_tx_data", TX_DATA, 8'h00);
    check("f_rst_tx_bytes", TX_BYTES, 32'd0);
    check("f_rst_ready", REQ_READY, 4'b0000);
    for (int i = 0; i < NR; i++) rq_hd[i] = rq_tl[i];
    exp_q.delete();
    for (int i = 0; i < NR; i++) load(i, 8'hA0 + 8'(i), 1);
    push_exp(8'hA0, 4);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    chk_en = 1'b1;
    @(negedge CLK); #2;
    check("f_sync_release", GRANT, 4'b0000);
    drain("f_drain");
    check("f_tx_bytes", TX_BYTES, 32'd4);

    // Counter wrap
    @(negedge CLK);
    force dut.tx_bytes_q = 32'hFFFF_FFFF;
    #1;
    release dut.tx_bytes_q;
    #1;
    check("g_preload", TX_BYTES, 32'hFFFF_FFFF);
    @(posedge CLK); #2;
    load(2, 8'hB0, 1);
    push_exp(8'hB0, 1);
    drain("g_drain");
    check("g_wrap", TX_BYTES, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tcp_tx_arbiter.md
TCP_TX_ARBITER -- requirements
Module: tcp_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the TCP TX byte stream; legal values 2..8.
REQ-002 Parameter MAX_BURST, default 256, maximum bytes accepted per grant; legal values 1..65535.
REQ-003 CLK  input  1  system clock (USRCLK domain, 125 MHz); all logic on its rising edge.
REQ-004 RSTn  input  1  asynchronous active-low reset, whole block.
REQ-005 TCP_OPEN  input  1  TCP connection established (MAIN_OPEN_ACK).
REQ-006 TCP_RST  input  1  SiTCP_RST, active-high, synchronous abort.
REQ-007 TX_FULL  input  1  TCP TX buffer almost-full flag.
REQ-008 TX_WR  output  1  TCP TX write enable.
REQ-009 TX_DATA  output  8  TCP TX write data.
REQ-010 REQ_VALID  input  N_REQ  per-requester byte valid.
REQ-011 REQ_DATA  input  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i].
REQ-012 REQ_LAST  input  N_REQ  per-requester last byte of packet.
REQ-013 REQ_READY  output  N_REQ  per-requester byte accepted this cycle.
REQ-014 GRANT  output  N_REQ  one-hot current grant, all zero when idle.
REQ-015 TX_BYTES  output  32  bytes written since last connection open.

Function
REQ-016 Beat accepted for requester i when REQ_VALID[i] and REQ_READY[i] are both high on a rising edge.
REQ-017 REQ_READY[i] = GRANT[i] & ~TX_FULL & TCP_OPEN & ~TCP_RST, combinational from registered GRANT.
REQ-018 Two states: IDLE and BUSY.
REQ-019 IDLE: GRANT all zero. If TCP_OPEN=1, TCP_RST=0 and any REQ_VALID=1, the next cycle is BUSY with GRANT set to the first valid requester searched round-robin from (last-served + 1) mod N_REQ. Arbitration therefore costs one cycle.
REQ-020 BUSY: grant is held; once granted, requesters are not preempted by other requesters.
REQ-021 BUSY: per-grant burst counter increments on each accepted beat.
REQ-022 BUSY -> IDLE when an accepted beat has REQ_LAST=1, or when it is beat number MAX_BURST.
REQ-023 On that transition, last-served is updated to the granted index.
REQ-024 BUSY with REQ_VALID deasserted: grant held indefinitely; there is no timeout.
REQ-025 BUSY -> IDLE immediately when TCP_OPEN=0 or TCP_RST=1. No beat is accepted in that cycle; last-served is updated; the requester's remaining bytes compete again later.
REQ-026 Each accepted beat produces TX_WR=1 and TX_DATA=beat data exactly one cycle later (registered).
REQ-027 TX_WR is otherwise 0. TX_DATA holds its last value when TX_WR=0.
REQ-028 The registered write of REQ-026 still issues if TCP_OPEN falls in the output cycle.
REQ-029 TX_FULL stalls acceptance with zero latency. At most one write (the in-flight registered one) issues after TX_FULL rises; the almost-full margin covers it.
REQ-030 Back-to-back beats: one byte per cycle sustained while ready.
REQ-031 TX_BYTES increments by 1 on each TX_WR=1 and wraps at 2^32-1 -> 0.
REQ-032 TX_BYTES clears to 0 on the rising edge of TCP_OPEN. If a write coincides with that edge, the clear wins.
REQ-033 Burst counter width is ceil(log2(MAX_BURST+1)); it clears on every BUSY entry.

Reset
REQ-034 RSTn low asynchronously forces: IDLE, GRANT=0, TX_WR=0, TX_DATA=0, TX_BYTES=0, burst counter=0, last-served=N_REQ-1 (first arbitration favours requester 0).
REQ-035 Release of RSTn is synchronised internally; the first state change occurs no earlier than the second CLK edge after release.
REQ-036 TCP_RST=1 acts as synchronous abort per REQ-025 but does not clear TX_BYTES or last-served.

Verification
REQ-037 N_REQ=4, TCP_OPEN=1, requesters 0 and 2 each valid with 3-byte packets -> output order 0,0,0,2,2,2; TX_WR one cycle after each accept; one idle cycle between packets.
REQ-038 MAX_BURST=4, requester 1 streams a 10-byte packet, requester 3 streams 2 bytes -> grant pattern 1(4 bytes), 3(2 bytes), 1(4 bytes), 1(2 bytes); TX_BYTES=12.
REQ-039 TX_FULL asserted mid-packet for 5 cycles -> REQ_READY=0 for those 5 cycles; exactly 0 or 1 TX_WR after the TX_FULL rise; no byte lost or duplicated.
REQ-040 TCP_OPEN dropped after byte 2 of a 6-byte packet -> GRANT=0 the next cycle; no further TX_WR beyond the in-flight byte; on reopen TX_BYTES=0 and the remaining 4 bytes are sent.
REQ-041 RSTn pulsed low mid-burst -> all outputs immediately 0; after release, requester 0 is served first when all are valid.
REQ-042 TX_BYTES preloaded via force to 32'hFFFF_FFFF, one write -> TX_BYTES=0.
